// File: rtl/gear_sel_pkg.sv
// gear_sel_pkg: switch bit indices, gear one-hot codes, default debounce length, priority encoder
package gear_sel_pkg;
  localparam int SW_D = 0;
  localparam int SW_N = 1;
  localparam int SW_R = 2;
  localparam int SW_P = 3;
  localparam logic [3:0] GEAR_P = 4'b1000;
  localparam logic [3:0] GEAR_R = 4'b0100;
  localparam logic [3:0] GEAR_N = 4'b0010;
  localparam logic [3:0] GEAR_D = 4'b0001;
  localparam int DEBOUNCE_DEFAULT = 16;
  function automatic logic [3:0] prio_gear(input logic [3:0] sw);
    return sw[SW_P] ? GEAR_P : sw[SW_R] ? GEAR_R : sw[SW_N] ? GEAR_N : sw[SW_D] ? GEAR_D : 4'b0000;
  endfunction
endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: two-flop synchroniser plus run-length debouncer for one switch
//   clk, reset (async, active-high); raw: bouncy async switch; clean: debounced level
module sw_debounce_bit
  import gear_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s1, s2;
  logic [CNT_W-1:0] cnt;
  // cnt counts consecutive cycles s2 differs from clean; any return to clean restarts it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      clean <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 == clean || cnt == LAST) ? '0 : cnt + CNT_W'(1);
      clean <= (s2 != clean && cnt == LAST) ? s2 : clean;
    end
endmodule

// File: rtl/gear_sel_conditioner.sv
// gear_sel_conditioner: debounces {P,R,N,D} switches and qualifies them to one gear request
//   clk, reset (async, active-high); sw_raw[3:0] {P,R,N,D} raw switches
//   sw_clean: debounced levels; sw_out: one-hot or 0000 gear request
//   sel_valid: sw_out reflects a legal selection; sel_change: 1-cycle pulse on sw_out change
//   SW_MULTI_REJECT_EN: multi-bit patterns rejected instead of priority-encoded P>R>N>D
module gear_sel_conditioner
  import gear_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_raw,
  output logic [3:0] sw_clean,
  output logic [3:0] sw_out,
  output logic       sel_valid,
  output logic       sel_change
);
  logic [3:0] out_next;
  logic valid_next;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    sw_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk(clk),
      .reset(reset),
      .raw(sw_raw[i]),
      .clean(sw_clean[i])
    );
  end
  // all-zero is the break-before-make gap: keep the last gear, flag it not valid
  always_comb begin
`ifdef SW_MULTI_REJECT_EN
    out_next = $onehot(sw_clean) ? sw_clean : sw_out;
    valid_next = $onehot(sw_clean);
`else
    out_next = (sw_clean == 4'b0000) ? sw_out : prio_gear(sw_clean);
    valid_next = |sw_clean;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sw_out <= 4'b0000;
      sel_valid <= 1'b0;
      sel_change <= 1'b0;
    end else begin
      sw_out <= out_next;
      sel_valid <= valid_next;
      sel_change <= out_next != sw_out;
    end
endmodule

// File: tb/tb_gear_sel_conditioner.sv
// tb_gear_sel_conditioner: randomized + directed scoreboard bench against a behavioural model
module tb_gear_sel_conditioner;
  localparam int DC = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] sw_raw = 4'b0000;
  logic [3:0] sw_clean, sw_out;
  logic sel_valid, sel_change;
  int checks = 0;
  int failures = 0;

  gear_sel_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .sw_clean(sw_clean),
    .sw_out(sw_out),
    .sel_valid(sel_valid),
    .sel_change(sel_change)
  );

  always #5 clk = ~clk;

  // model: raw samples per edge; a bit is accepted once the synchronised view
  // (raw two edges old) has disagreed with clean for DC consecutive edges
  logic [3:0] hist[$];
  logic [3:0] sb[$];
  logic [9:0] sbq[$];
  logic [3:0] m_clean = 4'b0, m_out = 4'b0, new_clean, nout;
  logic m_valid = 1'b0, m_chg = 1'b0, nv;

  always @(posedge clk) begin
    if (reset) begin
      hist = {};
      for (int i = 0; i < DC + 2; i++) hist.push_back(4'b0000);
      m_clean = 4'b0;
      m_out = 4'b0;
      m_valid = 1'b0;
      m_chg = 1'b0;
    end else begin
      hist.push_back(sw_raw);
      void'(hist.pop_front());
      new_clean = m_clean;
      for (int b = 0; b < 4; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int i = 0; i < DC; i++)
          if (hist[i][b] == m_clean[b]) all_diff = 1'b0;
        if (all_diff) new_clean[b] = ~m_clean[b];
      end
      if ($countones(m_clean) == 1) begin
        nout = m_clean;
        nv = 1'b1;
      end else if (m_clean == 4'b0) begin
        nout = m_out;
        nv = 1'b0;
      end else begin
`ifdef SW_MULTI_REJECT_EN
        nout = m_out;
        nv = 1'b0;
`else
        nout = 4'b0;
        for (int b = 0; b < 4; b++) if (m_clean[b]) nout = 4'(1 << b);
        nv = 1'b1;
`endif
      end
      m_chg = nout != m_out;
      m_out = nout;
      m_valid = nv;
      m_clean = new_clean;
    end
    sbq.push_back({m_clean, m_out, m_valid, m_chg});
  end

  // monitor: outputs are presented every cycle; one expectation per edge
  always @(negedge clk) begin
    logic [9:0] e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL sb_underflow: no expectation queued at %0t", $time);
    end else begin
      e = sbq.pop_front();
      if ({sw_clean, sw_out, sel_valid, sel_change} !== e) begin
        failures++;
        $display("FAIL cycle_check t=%0t: got clean=%b out=%b valid=%b chg=%b, expected clean=%b out=%b valid=%b chg=%b",
                 $time, sw_clean, sw_out, sel_valid, sel_change, e[9:6], e[5:2], e[1], e[0]);
      end
    end
  end

  task automatic hold(input logic [3:0] p, input int n);
    repeat (n) begin
      @(negedge clk);
      sw_raw = p;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({sw_clean, sw_out, sel_valid, sel_change} !== 10'b0) begin
      failures++;
      $display("FAIL async_reset: got clean=%b out=%b valid=%b chg=%b, expected all zero",
               sw_clean, sw_out, sel_valid, sel_change);
    end
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [3:0] p;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    hold(4'b0001, 12);
    for (int i = 0; i < 10; i++) hold((i % 2) ? 4'b0011 : 4'b0001, 2);
    hold(4'b0000, 10);
    hold(4'b1000, 12);
    hold(4'b0010, 12);
    hold(4'b1100, 12);
    hold(4'b0100, 5);
    pulse_reset();
    hold(4'b0100, 12);
    hold(4'b0001, 12);
    hold(4'b0010, 12);
    hold(4'b0111, 12);
    hold(4'b0000, 8);
    for (int s = 0; s < 80; s++) begin
      case ($urandom_range(0, 3))
        0: p = 4'(1 << $urandom_range(0, 3));
        1: p = 4'b0000;
        default: p = 4'($urandom_range(0, 15));
      endcase
      hold(p, $urandom_range(1, 10));
      if ($urandom_range(0, 3) == 0) hold(p ^ 4'($urandom_range(1, 15)), 1);
      if ($urandom_range(0, 30) == 0) pulse_reset();
    end
    hold(4'b0000, 12);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
